inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit.sv | 106 ++++++++++
 tb/tb_inst_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch FSM: REQ -> WAIT -> VALID, with 3-cycle issue and 1-cycle memory read latency.
// Backpressure: IR and decoded fields hold in VALID until ir_ready; a halt opcode parks the FSM until start.
module inst_fetch_unit #(
    parameter int         PC_W    = 5,
    parameter int         IR_W    = 32,
    parameter logic [4:0] HALT_OP = 5'd31
) (
    input  logic            clk,
    input  logic            sys_rst,
    input  logic            start,
    output logic            imem_rd,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IR_W-1:0] imem_rdata,
    output logic            ir_valid,
    input  logic            ir_ready,
    output logic [IR_W-1:0] IR,
    output logic [4:0]      oper_type,
    output logic [4:0]      rdst,
    output logic [4:0]      rsrc1,
    output logic            imm_mode,
    output logic [4:0]      rsrc2,
    output logic [15:0]     isrc,
    input  logic            jmp_en,
    input  logic [PC_W-1:0] jmp_addr,
    output logic            halted,
    output logic [15:0]     instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_HALTED
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;

    assign imem_addr = pc;
    assign oper_type = IR[31:27];
    assign rdst      = IR[26:22];
    assign rsrc1     = IR[21:17];
    assign imm_mode  = IR[16];
    assign rsrc2     = IR[15:11];
    assign isrc      = IR[15:0];

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            IR          <= '0;
            instr_count <= '0;
            ir_valid    <= 1'b0;
            imem_rd     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_REQ;
                        imem_rd <= 1'b1;
                    end
                end
                S_REQ: begin
                    state   <= S_WAIT;
                    imem_rd <= 1'b0;
                end
                S_WAIT: begin
                    IR       <= imem_rdata;
                    state    <= S_VALID;
                    ir_valid <= 1'b1;
                end
                S_VALID: begin
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        if (instr_count != 16'hFFFF) begin
                            instr_count <= instr_count + 16'd1;
                        end
                        // A halt opcode wins over any redirect presented with it.
                        if (oper_type == HALT_OP) begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end else begin
                            state   <= S_REQ;
                            imem_rd <= 1'b1;
                            pc      <= jmp_en ? jmp_addr : pc + PC_W'(1);
                        end
                    end
                end
                S_HALTED: begin
                    if (start) begin
                        state   <= S_REQ;
                        imem_rd <= 1'b1;
                        halted  <= 1'b0;
                        pc      <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed and randomized checks of inst_fetch_unit against a queue-based program-flow model.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        sys_rst, start, imem_rd, ir_valid, ir_ready, imm_mode, halted, jmp_en;
    logic [4:0]  imem_addr, jmp_addr, oper_type, rdst, rsrc1, rsrc2;
    logic [31:0] imem_rdata, IR;
    logic [15:0] isrc, instr_count;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk(clk), .sys_rst(sys_rst), .start(start),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .IR(IR),
        .oper_type(oper_type), .rdst(rdst), .rsrc1(rsrc1), .imm_mode(imm_mode),
        .rsrc2(rsrc2), .isrc(isrc), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
        .halted(halted), .instr_count(instr_count)
    );

    // Instruction memory: data appears the cycle after a read strobe, garbage otherwise.
    logic [31:0] mem [32];
    always @(posedge clk) imem_rdata <= imem_rd ? mem[imem_addr] : $urandom();

    int total = 0;
    int bad   = 0;
    int n_hs  = 0;

    // Reference model: program flow expressed as expected fetch addresses and IR words.
    logic [31:0] exp_ir[$];
    logic [4:0]  exp_addr[$];
    logic [4:0]  m_pc;
    logic [15:0] m_count;
    bit          m_idle, m_halt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_ir.delete();
        exp_addr.delete();
        m_pc    = 5'd0;
        m_count = 16'd0;
        m_idle  = 1'b1;
        m_halt  = 1'b0;
    endtask

    task automatic push_fetch(input logic [4:0] a);
        exp_addr.push_back(a);
        exp_ir.push_back(mem[a]);
    endtask

    task automatic issue_start();
        start = 1'b1;
        if (m_idle) begin
            m_idle = 1'b0;
            m_pc   = 5'd0;
            push_fetch(5'd0);
        end
        step();
        start = 1'b0;
    endtask

    task automatic accept(input logic jen, input logic [4:0] ja);
        int n = 0;
        while (!ir_valid && n < 20) begin
            step();
            n++;
        end
        chk("accept_wait", ir_valid, 1);
        ir_ready = 1'b1;
        jmp_en   = jen;
        jmp_addr = ja;
        step();
        ir_ready = 1'b0;
        jmp_en   = 1'b0;
        jmp_addr = $urandom();
    endtask

    // Monitor: checks fetch addresses and accepted instructions, advances the model on handshakes.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!sys_rst) begin
                chk("halted", halted, m_halt);
                if (start && m_halt) m_halt = 1'b0;
                if (imem_rd) begin
                    if (exp_addr.size() == 0) chk("fetch_pending", 0, 1);
                    else chk("fetch_addr", imem_addr, exp_addr.pop_front());
                end
                if (ir_valid && ir_ready) begin
                    n_hs++;
                    if (exp_ir.size() == 0) chk("hs_pending", 0, 1);
                    else begin
                        e = exp_ir.pop_front();
                        chk("ir", IR, e);
                        chk("oper_type", oper_type, e[31:27]);
                        chk("rdst", rdst, e[26:22]);
                        chk("rsrc1", rsrc1, e[21:17]);
                        chk("imm_mode", imm_mode, e[16]);
                        chk("rsrc2", rsrc2, e[15:11]);
                        chk("isrc", isrc, e[15:0]);
                        chk("count", instr_count, m_count);
                        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                        if (e[31:27] == 5'd31) begin
                            m_idle = 1'b1;
                            m_halt = 1'b1;
                        end else begin
                            m_pc = jmp_en ? jmp_addr : m_pc + 5'd1;
                            push_fetch(m_pc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] ir_hold;
        sys_rst = 1'b1; start = 1'b0; ir_ready = 1'b0; jmp_en = 1'b0; jmp_addr = 5'd0;
        model_reset();
        for (int i = 0; i < 32; i++) mem[i] = {5'($urandom_range(0, 30)), 27'($urandom())};
        mem[0] = 32'h1000_4004;
        mem[2] = {5'd31, 27'($urandom())};
        repeat (3) step();
        sys_rst = 1'b0;
        chk("rst_imem_rd", imem_rd, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_ir", IR, 0);
        chk("rst_addr", imem_addr, 0);

        // First fetch latency and field slicing.
        issue_start();
        chk("lat_rd", imem_rd, 1);
        chk("lat_addr", imem_addr, 0);
        step();
        chk("lat_wait_rd", imem_rd, 0);
        chk("lat_wait_valid", ir_valid, 0);
        step();
        chk("lat_valid", ir_valid, 1);
        chk("lat_ir", IR, 32'h1000_4004);
        chk("lat_oper", oper_type, 2);
        chk("lat_rsrc2", rsrc2, 8);
        chk("lat_isrc", isrc, 16'h4004);
        chk("lat_imm", imm_mode, 0);

        // Stall in VALID; a start pulse here must be ignored.
        ir_hold = IR;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            step();
            chk("stall_valid", ir_valid, 1);
            chk("stall_ir", IR, ir_hold);
            chk("stall_rd", imem_rd, 0);
            chk("stall_count", instr_count, 0);
        end
        start = 1'b0;
        accept(1'b0, 5'd0);
        chk("seq_addr1", imem_addr, 1);
        chk("seq_count1", instr_count, 1);
        accept(1'b1, 5'd20);
        chk("jmp_addr20", imem_addr, 20);
        accept(1'b1, 5'd31);
        chk("jmp_addr31", imem_addr, 31);
        accept(1'b0, 5'd0);
        chk("wrap_addr0", imem_addr, 0);
        accept(1'b0, 5'd0);
        accept(1'b0, 5'd0);
        chk("seq_addr2", imem_addr, 2);
        accept(1'b1, 5'd7);
        for (int i = 0; i < 4; i++) begin
            chk("halt_flag", halted, 1);
            chk("halt_no_rd", imem_rd, 0);
            step();
        end
        issue_start();
        chk("restart_rd", imem_rd, 1);
        chk("restart_addr", imem_addr, 0);
        chk("restart_count", instr_count, 7);
        step();
        chk("wait_no_valid", ir_valid, 0);

        // Reset in the middle of the WAIT state.
        sys_rst = 1'b1;
        model_reset();
        step();
        sys_rst = 1'b0;
        chk("wrst_ir", IR, 0);
        chk("wrst_addr", imem_addr, 0);
        chk("wrst_count", instr_count, 0);
        chk("wrst_valid", ir_valid, 0);
        chk("wrst_rd", imem_rd, 0);
        step();
        chk("wrst_idle_rd", imem_rd, 0);

        // Counter saturation from a preloaded value.
        force dut.instr_count = 16'hFFFD;
        step();
        release dut.instr_count;
        m_count = 16'hFFFD;
        step();
        chk("sat_preload", instr_count, 16'hFFFD);
        issue_start();
        accept(1'b0, 5'd0);
        accept(1'b0, 5'd0);
        accept(1'b0, 5'd0);
        step();
        chk("sat_count", instr_count, 16'hFFFF);
        chk("sat_halted", halted, 1);

        // Randomized traffic: backpressure, jumps, halts and restarts.
        sys_rst = 1'b1;
        model_reset();
        step();
        sys_rst = 1'b0;
        for (int i = 0; i < 32; i++)
            mem[i] = {($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30)), 27'($urandom())};
        n_hs = 0;
        for (int c = 0; c < 3000; c++) begin
            ir_ready = ($urandom_range(0, 3) != 0);
            jmp_en   = ($urandom_range(0, 3) == 0);
            jmp_addr = 5'($urandom());
            start    = ($urandom_range(0, 4) == 0);
            if (start && m_idle) begin
                m_idle = 1'b0;
                m_pc   = 5'd0;
                push_fetch(5'd0);
            end
            step();
        end
        start = 1'b0; ir_ready = 1'b1; jmp_en = 1'b0;
        repeat (10) step();
        chk("progress", (n_hs > 100) ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
